fir_controller: RTL and testbench

- Control FSM and result-capture stage for the serial-MAC FIR datapath (LENGTH taps, WIDTH-bit samples/coefficients, 2*WIDTH+6-bit accumulator).
- Accepts one sample per valid/ready handshake and drives the datapath shift, count, accumulator-enable and accumulator-clear strobes.
- Watches dp_rollBack to detect the last tap, latches the final sum, and presents it on a valid/ready output port.
- Detects tap-count desynchronisation with the datapath and resynchronises it.

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_tap_watchdog.sv | 33 +++
 rtl/fir_controller.sv | 121 ++++++++++++
 tb/tb_fir_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the serial-MAC FIR controller: state encoding,
// datapath strobe bundle and width helpers.
package fir_pkg;

    // Controller states
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;
    localparam logic [1:0] RECOVER = 2'd3;

    // Datapath strobes decoded from the controller state
    typedef struct packed {
        logic shift;     // shift sample into register file
        logic count;     // advance tap pointer
        logic acc_load;  // accumulator load enable
        logic acc_clr;   // accumulator clear
    } dp_ctrl_t;

    // Accumulator width: product (2*WIDTH) plus headroom for the tap sum
    function automatic int calc_acc_w(input int width);
        return 2 * width + 6;
    endfunction

    // Tap counter width, never less than one bit
    function automatic int calc_tap_cnt_w(input int length);
        return (length > 1) ? $clog2(length) : 1;
    endfunction

endpackage

// File: rtl/fir_tap_watchdog.sv
// Local tap counter shadowing the datapath pointer. Flags the last tap and
// any disagreement between the datapath rollBack and the local count.
module fir_tap_watchdog
    import fir_pkg::*;
#(
    parameter int LENGTH = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic check,
    input  logic roll_back,
    output logic is_last,
    output logic sync_error
);

    localparam int TAP_CNT_W = calc_tap_cnt_w(LENGTH);

    logic [TAP_CNT_W-1:0] tap_cnt;

    // Count taps; hold at the last tap since the FSM always leaves ACCUM there
    always_ff @(posedge clk) begin
        if (rst || clr)
            tap_cnt <= '0;
        else if (inc && !is_last)
            tap_cnt <= tap_cnt + 1'b1;
    end

    assign is_last    = (tap_cnt == TAP_CNT_W'(LENGTH - 1));
    assign sync_error = check & (roll_back ^ is_last);

endmodule

// File: rtl/fir_controller.sv
// Control FSM and result-capture stage for the serial-MAC FIR datapath.
// One sample per handshake, LENGTH accumulate cycles, one result per handshake.
module fir_controller
    import fir_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH+5:0]   out_data,
    output logic                 err_sync,
    output logic                 dp_rst,
    output logic                 dp_shift_enb,
    output logic [WIDTH-1:0]     dp_in,
    output logic                 dp_count_enb,
    output logic                 register_enb,
    output logic                 resetReg,
    input  logic                 dp_rollBack,
    input  logic [2*WIDTH+5:0]   dp_out
);

    localparam int ACC_W = calc_acc_w(WIDTH);

    logic [1:0]       state, state_nxt;
    dp_ctrl_t         ctl;
    logic             tap_clr, tap_inc, capture, err_set;
    logic             is_last, sync_error;
    logic [ACC_W-1:0] out_q;
    logic             err_q;

    fir_tap_watchdog #(.LENGTH(LENGTH)) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .clr        (tap_clr),
        .inc        (tap_inc),
        .check      (!rst && state == ACCUM),
        .roll_back  (dp_rollBack),
        .is_last    (is_last),
        .sync_error (sync_error)
    );

    // Next-state and strobe decode; everything is forced quiet while in reset
    always_comb begin
        state_nxt = state;
        ctl       = '0;
        tap_clr   = 1'b0;
        tap_inc   = 1'b0;
        capture   = 1'b0;
        err_set   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        ctl.shift   = 1'b1;
                        ctl.acc_clr = 1'b1;
                        tap_clr     = 1'b1;
                        state_nxt   = ACCUM;
                    end
                end
                ACCUM: begin
                    // rollBack early or missing: datapath pointer is out of step
                    if (sync_error) begin
                        err_set   = 1'b1;
                        state_nxt = RECOVER;
                    end
                    if (!dp_rollBack) begin
                        ctl.count    = 1'b1;
                        ctl.acc_load = 1'b1;
                        tap_inc      = 1'b1;
                    end else if (is_last) begin
                        // final tap: take the adder output, wrap pointer to 0
                        capture   = 1'b1;
                        ctl.count = 1'b1;
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    out_valid = 1'b1;
                    if (out_ready)
                        state_nxt = IDLE;
                end
                RECOVER: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, result capture and sticky sync error
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture)
                out_q <= dp_out;
            if (err_set)
                err_q <= 1'b1;
        end
    end

    assign dp_rst       = rst | (state == RECOVER);
    assign dp_shift_enb = ctl.shift;
    assign dp_count_enb = ctl.count;
    assign register_enb = ctl.acc_load;
    assign resetReg     = ctl.acc_clr;
    assign dp_in        = rst ? '0 : in_data;
    assign out_data     = rst ? '0 : out_q;
    assign err_sync     = rst ? 1'b0 : err_q;

endmodule

// File: tb/tb_fir_controller.sv
// Bench for fir_controller: a behavioural serial-MAC datapath drives the DUT
// and every result is compared with a direct FIR sum over the sample history.
module tb_fir_controller;

    localparam int WIDTH  = 8;
    localparam int LENGTH = 50;
    localparam int ACC_W  = 2 * WIDTH + 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_ready = 1'b0;
    logic             in_ready, out_valid, err_sync, dp_rst;
    logic             dp_shift_enb, dp_count_enb, register_enb, resetReg;
    logic [WIDTH-1:0] dp_in;
    logic [ACC_W-1:0] out_data, dp_out;
    logic             dp_rollBack;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    fir_controller #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .err_sync     (err_sync),
        .dp_rst       (dp_rst),
        .dp_shift_enb (dp_shift_enb),
        .dp_in        (dp_in),
        .dp_count_enb (dp_count_enb),
        .register_enb (register_enb),
        .resetReg     (resetReg),
        .dp_rollBack  (dp_rollBack),
        .dp_out       (dp_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- datapath model ----------------
    logic signed [WIDTH-1:0]   coef [LENGTH];
    logic signed [WIDTH-1:0]   xreg [LENGTH] = '{default: '0};
    logic signed [ACC_W-1:0]   acc = '0;
    logic signed [2*WIDTH-1:0] prod;
    int ptr = 0;
    int dp_mode = 0;   // 0: rollBack at last tap, 1: early at tap 20, 2: never

    always @(posedge clk) begin
        if (dp_rst) begin
            ptr <= 0;
            acc <= '0;
        end else begin
            if (dp_count_enb) ptr <= (ptr == LENGTH - 1) ? 0 : ptr + 1;
            if (resetReg) acc <= '0;
            else if (register_enb) acc <= dp_out;
        end
        if (dp_shift_enb) begin
            for (int k = LENGTH - 1; k > 0; k--) xreg[k] <= xreg[k-1];
            xreg[0] <= dp_in;
        end
    end

    assign prod        = xreg[ptr] * coef[ptr];
    assign dp_out      = acc + {{(ACC_W - 2*WIDTH){prod[2*WIDTH-1]}}, prod};
    assign dp_rollBack = (dp_mode == 0) ? (ptr == LENGTH - 1) :
                         (dp_mode == 1) ? (ptr == 20) : 1'b0;

    // ---------------- reference model ----------------
    int hist[$];   // every sample shifted into the filter, newest first

    function automatic logic [ACC_W-1:0] ref_fir();
        int s = 0;
        for (int k = 0; k < LENGTH && k < hist.size(); k++)
            s += int'(coef[k]) * hist[k];
        return ACC_W'(s);
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst_outs(input string tag);
        chk({tag, "_ctl"}, {in_ready, out_valid, err_sync, dp_shift_enb,
                            dp_count_enb, register_enb, resetReg}, 32'd0);
        chk({tag, "_data"}, {out_data, dp_in}, 32'd0);
        chk({tag, "_dp_rst"}, dp_rst, 32'd1);
    endtask

    // Present one sample in IDLE and follow it through to the result handshake.
    // bp: extra DONE cycles with out_ready low; hold: keep in_valid high.
    task automatic run_one(input int bp, input bit hold, output int t_out);
        int nreg = 0, ncnt = 0, nbad = 0;
        logic [ACC_W-1:0] exp;
        in_valid  = 1'b1;
        in_data   = WIDTH'($urandom);
        out_ready = (bp == 0);
        #1;
        chk("idle_in_ready", in_ready, 32'd1);
        chk("accept_strobes", {dp_shift_enb, resetReg, dp_count_enb, register_enb}, 32'b1100);
        chk("dp_in_copy", dp_in, in_data);
        hist.push_front(int'($signed(in_data)));
        exp = ref_fir();
        for (int k = 1; k <= LENGTH; k++) begin
            nxt();
            in_valid = hold;
            #1;
            nreg += int'(register_enb);
            ncnt += int'(dp_count_enb);
            if (in_ready || out_valid || dp_shift_enb || resetReg || dp_rst) nbad++;
            if (k == LENGTH) chk("last_tap_reg_enb", register_enb, 32'd0);
        end
        chk("accum_reg_enb_cycles", nreg, LENGTH - 1);
        chk("accum_count_enb_cycles", ncnt, LENGTH);
        chk("accum_spurious", nbad, 32'd0);
        nxt();
        #1;
        t_out = cyc;
        chk("done_out_valid", out_valid, 32'd1);
        chk("out_data", out_data, exp);
        chk("done_in_ready", in_ready, 32'd0);
        nbad = 0;
        for (int b = 0; b < bp; b++) begin
            nxt();
            #1;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready || dp_shift_enb ||
                dp_count_enb || register_enb || resetReg || dp_rst) nbad++;
        end
        chk("backpressure_hold", nbad, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("release_out_valid", out_valid, 32'd1);
        nxt();
        #1;
        chk("back_to_idle_in_ready", in_ready, 32'd1);
        chk("back_to_idle_out_valid", out_valid, 32'd0);
    endtask

    // Sample with a misbehaving rollBack: expect one RECOVER cycle, no result
    task automatic run_err(input int mode);
        int exp_rc, rc_at = -1, n_rst = 0, n_ov = 0;
        dp_mode   = mode;
        exp_rc    = (mode == 1) ? 22 : LENGTH + 1;
        in_valid  = 1'b1;
        in_data   = WIDTH'($urandom);
        out_ready = 1'b1;
        #1;
        chk("err_accept", in_ready, 32'd1);
        hist.push_front(int'($signed(in_data)));
        for (int k = 1; k <= LENGTH + 4; k++) begin
            nxt();
            in_valid = 1'b0;
            #1;
            if (dp_rst) begin
                n_rst++;
                rc_at = k;
            end
            n_ov += int'(out_valid);
            if (k == exp_rc) chk("err_sync_set", err_sync, 32'd1);
            if (k == exp_rc + 1) chk("recover_to_idle", in_ready, 32'd1);
        end
        chk("recover_pulse_count", n_rst, 32'd1);
        chk("recover_cycle", rc_at, exp_rc);
        chk("err_no_out_valid", n_ov, 32'd0);
        dp_mode = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0, t1, t2, n_bad;
        for (int k = 0; k < LENGTH; k++) coef[k] = WIDTH'($urandom);

        // reset with live-looking inputs: outputs must stay quiet
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) nxt();
        chk_rst_outs("reset");
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 32'd1);
        chk("post_reset_err_sync", err_sync, 32'd0);
        chk("post_reset_out_data", out_data, 32'd0);

        // nominal and backpressure
        run_one(0, 1'b0, t0);
        chk("nominal_no_err", err_sync, 32'd0);
        run_one(10, 1'b0, t0);

        // early rollBack, then a clean sample with err_sync sticky
        run_err(1);
        run_one(0, 1'b0, t0);
        chk("err_sticky", err_sync, 32'd1);

        // missing rollBack
        run_err(2);

        // reset in the middle of ACCUM (tap 30)
        in_valid  = 1'b1;
        in_data   = WIDTH'($urandom);
        out_ready = 1'b1;
        #1;
        hist.push_front(int'($signed(in_data)));
        for (int k = 1; k <= 31; k++) begin
            nxt();
            in_valid = 1'b0;
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hC3;
        #1;
        chk_rst_outs("mid_reset_c1");
        nxt();
        chk_rst_outs("mid_reset_c2");
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_reset_in_ready", in_ready, 32'd1);
        chk("mid_reset_err_clr", err_sync, 32'd0);
        chk("mid_reset_dp_rst", dp_rst, 32'd0);
        n_bad = 0;
        for (int k = 0; k < LENGTH + 5; k++) begin
            nxt();
            if (out_valid || !in_ready) n_bad++;
        end
        chk("mid_reset_no_stale_result", n_bad, 32'd0);

        // back-to-back with in_valid held high
        run_one(0, 1'b1, t0);
        run_one(0, 1'b1, t1);
        run_one(0, 1'b1, t2);
        in_valid = 1'b0;
        chk("b2b_spacing_1", t1 - t0, LENGTH + 2);
        chk("b2b_spacing_2", t2 - t1, LENGTH + 2);

        // random backpressure
        for (int i = 0; i < 4; i++) run_one(int'($urandom_range(0, 3)), 1'b0, t0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
